// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional macro IDEX_STALL_STATS_EN adds saturating stall/bubble counters.
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        ex_in,
  input  logic [1:0]        mem_in,
  input  logic [1:0]        wb_in,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [4:0]        rs_in,
  input  logic [4:0]        rt_in,
  input  logic [4:0]        rd_in,
  input  logic              flush,
  output logic [4:0]        ex_out,
  output logic [1:0]        mem_out,
  output logic [1:0]        wb_out,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [4:0]        rs_out,
  output logic [4:0]        rt_out,
  output logic [4:0]        rd_out,
  output logic              stall,
  output logic              valid_out
`ifdef IDEX_STALL_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
`endif
);

  logic [4:0]        ex_p0;
  logic [1:0]        mem_p0;
  logic [1:0]        wb_p0;
  logic [DATA_W-1:0] rd1_p0;
  logic [DATA_W-1:0] rd2_p0;
  logic [DATA_W-1:0] imm_p0;
  logic [4:0]        rs_p0;
  logic [4:0]        rt_p0;
  logic [4:0]        rd_p0;
  logic              vld_p0;
  logic              bubble;

  function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Only the registered EX-stage load and the decode source specifiers feed stall.
  always_comb begin
    stall = 1'b0;
    if (mem_p0[0] && (rt_p0 != 5'd0) && ((rt_p0 == rs_in) || (rt_p0 == rt_in)))
      stall = 1'b1;
  end

  assign bubble = stall | flush;

  // ID -> EX boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_p0  <= '0;
      mem_p0 <= '0;
      wb_p0  <= '0;
      rd1_p0 <= '0;
      rd2_p0 <= '0;
      imm_p0 <= '0;
      rs_p0  <= '0;
      rt_p0  <= '0;
      rd_p0  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      rd1_p0 <= rd1_in;
      rd2_p0 <= rd2_in;
      imm_p0 <= imm_in;
      if (bubble) begin
        ex_p0  <= '0;
        mem_p0 <= '0;
        wb_p0  <= '0;
        rs_p0  <= '0;
        rt_p0  <= '0;
        rd_p0  <= '0;
        vld_p0 <= 1'b0;
      end else begin
        ex_p0  <= ex_in;
        mem_p0 <= mem_in;
        wb_p0  <= wb_in;
        rs_p0  <= rs_in;
        rt_p0  <= rt_in;
        rd_p0  <= rd_in;
        vld_p0 <= 1'b1;
      end
    end
  end

  assign ex_out    = ex_p0;
  assign mem_out   = mem_p0;
  assign wb_out    = wb_p0;
  assign rd1_out   = rd1_p0;
  assign rd2_out   = rd2_p0;
  assign imm_out   = imm_p0;
  assign rs_out    = rs_p0;
  assign rt_out    = rt_p0;
  assign rd_out    = rd_p0;
  assign valid_out = vld_p0;

`ifdef IDEX_STALL_STATS_EN
  logic [15:0] stall_cnt_p0;
  logic [15:0] bubble_cnt_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_p0  <= '0;
      bubble_cnt_p0 <= '0;
    end else begin
      if (stall)  stall_cnt_p0  <= sat_inc16(stall_cnt_p0);
      if (bubble) bubble_cnt_p0 <= sat_inc16(bubble_cnt_p0);
    end
  end

  assign stall_cnt  = stall_cnt_p0;
  assign bubble_cnt = bubble_cnt_p0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, load-use, $0 guard, flush,
// reset dominance and (with IDEX_STALL_STATS_EN) counter behaviour.
module tb_id_ex_stage;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [4:0]        ex_in;
  logic [1:0]        mem_in;
  logic [1:0]        wb_in;
  logic [DATA_W-1:0] rd1_in, rd2_in, imm_in;
  logic [4:0]        rs_in, rt_in, rd_in;
  logic              flush;
  logic [4:0]        ex_out;
  logic [1:0]        mem_out;
  logic [1:0]        wb_out;
  logic [DATA_W-1:0] rd1_out, rd2_out, imm_out;
  logic [4:0]        rs_out, rt_out, rd_out;
  logic              stall;
  logic              valid_out;
`ifdef IDEX_STALL_STATS_EN
  logic [15:0]       stall_cnt, bubble_cnt;
`endif

  int tests = 0;
  int fails = 0;

  id_ex_stage #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_in(ex_in), .mem_in(mem_in), .wb_in(wb_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .flush(flush),
    .ex_out(ex_out), .mem_out(mem_out), .wb_out(wb_out),
    .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
    .stall(stall), .valid_out(valid_out)
`ifdef IDEX_STALL_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] ex, input logic [1:0] mem, input logic [1:0] wb,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    ex_in  = ex;
    mem_in = mem;
    wb_in  = wb;
    rs_in  = rs;
    rt_in  = rt;
    rd_in  = rd;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".ex"},    64'(ex_out),    64'd0);
    chk({tag, ".mem"},   64'(mem_out),   64'd0);
    chk({tag, ".wb"},    64'(wb_out),    64'd0);
    chk({tag, ".rs"},    64'(rs_out),    64'd0);
    chk({tag, ".rt"},    64'(rt_out),    64'd0);
    chk({tag, ".rd"},    64'(rd_out),    64'd0);
    chk({tag, ".valid"}, 64'(valid_out), 64'd0);
  endtask

  initial begin
    // Reset with random inputs
    rst_n  = 1'b0;
    flush  = 1'b0;
    ex_in  = 5'($urandom);
    mem_in = 2'($urandom);
    wb_in  = 2'($urandom);
    rd1_in = $urandom;
    rd2_in = $urandom;
    imm_in = $urandom;
    rs_in  = 5'($urandom);
    rt_in  = 5'($urandom);
    rd_in  = 5'($urandom);
    step();
    chk_bubble("rst");
    chk("rst.rd1",   64'(rd1_out), 64'd0);
    chk("rst.rd2",   64'(rd2_out), 64'd0);
    chk("rst.imm",   64'(imm_out), 64'd0);
    chk("rst.stall", 64'(stall),   64'd0);

    // Pass-through
    rst_n = 1'b1;
    drive(5'b01010, 2'b00, 2'b01, 5'd1, 5'd2, 5'd5);
    rd1_in = 32'h1234_5678;
    rd2_in = 32'hCAFE_0001;
    imm_in = 32'hFFFF_FFF0;
    step();
    chk("pass.ex",    64'(ex_out),    64'b01010);
    chk("pass.mem",   64'(mem_out),   64'd0);
    chk("pass.wb",    64'(wb_out),    64'b01);
    chk("pass.rd1",   64'(rd1_out),   64'h1234_5678);
    chk("pass.rd2",   64'(rd2_out),   64'hCAFE_0001);
    chk("pass.imm",   64'(imm_out),   64'hFFFF_FFF0);
    chk("pass.rs",    64'(rs_out),    64'd1);
    chk("pass.rt",    64'(rt_out),    64'd2);
    chk("pass.rd",    64'(rd_out),    64'd5);
    chk("pass.valid", 64'(valid_out), 64'd1);
    chk("pass.stall", 64'(stall),     64'd0);

    // Load-use on rs
    drive(5'b10000, 2'b01, 2'b11, 5'd3, 5'd8, 5'd0);
    step();
    chk("lw.mem",   64'(mem_out), 64'b01);
    chk("lw.rt",    64'(rt_out),  64'd8);
    drive(5'b00010, 2'b00, 2'b01, 5'd8, 5'd9, 5'd10);
    #1;
    chk("lu.stall", 64'(stall), 64'd1);
    step();
    chk_bubble("lu.bub");
    chk("lu.stall_after", 64'(stall), 64'd0);
    step();
    chk("lu.dep.ex",    64'(ex_out),    64'b00010);
    chk("lu.dep.rs",    64'(rs_out),    64'd8);
    chk("lu.dep.rd",    64'(rd_out),    64'd10);
    chk("lu.dep.valid", 64'(valid_out), 64'd1);
`ifdef IDEX_STALL_STATS_EN
    chk("lu.stall_cnt",  64'(stall_cnt),  64'd1);
    chk("lu.bubble_cnt", 64'(bubble_cnt), 64'd1);
`endif

    // Load-use through rt
    drive(5'b10000, 2'b01, 2'b11, 5'd4, 5'd12, 5'd0);
    step();
    drive(5'b00001, 2'b00, 2'b01, 5'd6, 5'd12, 5'd13);
    #1;
    chk("lu_rt.stall", 64'(stall), 64'd1);
    step();
    chk("lu_rt.valid", 64'(valid_out), 64'd0);

    // $0 guard
    drive(5'b10000, 2'b01, 2'b11, 5'd4, 5'd0, 5'd0);
    step();
    chk("z.mem", 64'(mem_out), 64'b01);
    drive(5'b00011, 2'b00, 2'b01, 5'd0, 5'd0, 5'd7);
    #1;
    chk("z.stall", 64'(stall), 64'd0);
    step();
    chk("z.valid", 64'(valid_out), 64'd1);
    chk("z.rd",    64'(rd_out),    64'd7);

    // Flush alone
    drive(5'b11111, 2'b11, 2'b11, 5'd21, 5'd22, 5'd23);
    flush = 1'b1;
    step();
    chk_bubble("fl");
    flush = 1'b0;

    // Flush + stall from a clean reset: exactly one bubble
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(5'b10000, 2'b01, 2'b11, 5'd1, 5'd7, 5'd0);
    step();
    drive(5'b00100, 2'b00, 2'b01, 5'd7, 5'd2, 5'd14);
    flush = 1'b1;
    #1;
    chk("fs.stall", 64'(stall), 64'd1);
    step();
    chk_bubble("fs.bub");
    flush = 1'b0;
    step();
    chk("fs.next.valid", 64'(valid_out), 64'd1);
    chk("fs.next.rd",    64'(rd_out),    64'd14);
`ifdef IDEX_STALL_STATS_EN
    chk("fs.stall_cnt",  64'(stall_cnt),  64'd1);
    chk("fs.bubble_cnt", 64'(bubble_cnt), 64'd1);
`endif

    // Reset dominates a pending stall
    drive(5'b10000, 2'b01, 2'b11, 5'd1, 5'd9, 5'd0);
    step();
    drive(5'b00110, 2'b00, 2'b01, 5'd9, 5'd3, 5'd17);
    #1;
    chk("rs.stall_pre", 64'(stall), 64'd1);
    rst_n = 1'b0;
    step();
    chk_bubble("rs.rst");
    chk("rs.stall", 64'(stall), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rs.rel.valid", 64'(valid_out), 64'd1);
    chk("rs.rel.ex",    64'(ex_out),    64'b00110);
    chk("rs.rel.rd",    64'(rd_out),    64'd17);

`ifdef IDEX_STALL_STATS_EN
    // Bubble counter saturation
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    flush = 1'b1;
    repeat (65540) step();
    chk("sat.bubble_cnt", 64'(bubble_cnt), 64'hFFFF);
    flush = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
